// File: rtl/restoring_divider32_if.sv
// Handshake and operand/result bundle between the issuing control FSM and restoring_divider32.
// DIV_SIGNED_EN adds the signed_op request bit.
interface restoring_divider32_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIV_SIGNED_EN
    logic        signed_op;
`endif
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

`ifdef DIV_SIGNED_EN
    modport master (
        output start, dividend, divisor, signed_op,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, signed_op,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/restoring_divider32.sv
// Multicycle 32-bit restoring divider, one quotient bit per clock, plus its trial-subtract adder.
// Optional macro DIV_SIGNED_EN: signed operands via magnitude load and a one-cycle FIXUP state.
module restoring_divider32 #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    restoring_divider32_if.slave  bus
);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

    function automatic logic [31:0] f_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [31:0] r_divisor;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;
    logic        r_dbz;
    logic        r_done;
`ifdef DIV_SIGNED_EN
    logic        r_neg_q;
    logic        r_neg_r;
    logic        w_dd_neg;
    logic        w_dv_neg;
`endif

    logic        w_load;
    logic        w_early;
    logic        w_iter;
    logic        w_finish;
    logic        w_fixup;

    logic [31:0] w_shift;
    logic [31:0] w_sum;
    logic        w_cout;
    logic        w_success;
    logic [31:0] w_rem_next;
    logic [31:0] w_q_next;
    logic [31:0] w_dd_load;
    logic [31:0] w_dv_load;

    // Trial subtract of the shifted remainder's low 32 bits; bit 32 lives in r_rem[31].
    assign w_shift = {r_rem[30:0], r_q[31]};

    AdderAndSuber32bits u_trial_sub (
        .A    (w_shift),
        .B    (r_divisor),
        .Cin  (1'b1),
        .S    (w_sum),
        .Cout (w_cout)
    );

    assign w_success  = r_rem[31] | w_cout;
    assign w_rem_next = w_success ? w_sum : w_shift;
    assign w_q_next   = {r_q[30:0], w_success};

`ifdef DIV_SIGNED_EN
    assign w_dd_neg  = bus.signed_op & bus.dividend[31];
    assign w_dv_neg  = bus.signed_op & bus.divisor[31];
    assign w_dd_load = w_dd_neg ? f_neg(bus.dividend) : bus.dividend;
    assign w_dv_load = w_dv_neg ? f_neg(bus.divisor)  : bus.divisor;
`else
    assign w_dd_load = bus.dividend;
    assign w_dv_load = bus.divisor;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_load       = 1'b0;
        w_early      = 1'b0;
        w_iter       = 1'b0;
        w_finish     = 1'b0;
        w_fixup      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (EARLY_ZERO && (bus.divisor == 32'd0)) begin
                        w_early = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_iter = 1'b1;
                if (r_count == 5'd31) begin
`ifdef DIV_SIGNED_EN
                    w_state_next = S_FIXUP;
`else
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIXUP: begin
                w_fixup      = 1'b1;
                w_state_next = S_IDLE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            if (w_early) begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_dbz       <= 1'b1;
                r_done      <= 1'b1;
            end

            if (w_load) begin
                r_rem     <= '0;
                r_q       <= w_dd_load;
                r_divisor <= w_dv_load;
                r_count   <= '0;
                r_dbz     <= 1'b0;
`ifdef DIV_SIGNED_EN
                r_neg_q   <= w_dd_neg ^ w_dv_neg;
                r_neg_r   <= w_dd_neg;
`endif
            end

            if (w_iter) begin
                r_rem   <= w_rem_next;
                r_q     <= w_q_next;
                r_count <= r_count + 5'd1;
            end

            if (w_finish) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_rem_next;
                r_dbz       <= (r_divisor == 32'd0);
                r_done      <= 1'b1;
            end

`ifdef DIV_SIGNED_EN
            // A zero divisor keeps the all-ones quotient; the remainder sign fixup then
            // reproduces the original dividend.
            if (w_fixup) begin
                r_quotient  <= (r_neg_q && (r_divisor != 32'd0)) ? f_neg(r_q) : r_q;
                r_remainder <= r_neg_r ? f_neg(r_rem) : r_rem;
                r_dbz       <= (r_divisor == 32'd0);
                r_done      <= 1'b1;
            end
`endif
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// 32-bit adder/subtractor: Cin=1 inverts B and adds one, so Cout=1 means no borrow.
module AdderAndSuber32bits (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);
    logic [32:0] w_sum;

    assign w_sum = {1'b0, A} + {1'b0, (B ^ {32{Cin}})} + {32'd0, Cin};
    assign S     = w_sum[31:0];
    assign Cout  = w_sum[32];
endmodule

// File: tb/tb_restoring_divider32.sv
// Directed-vector bench for restoring_divider32 (EARLY_ZERO=1 and EARLY_ZERO=0 instances).
// Signed vectors are included when DIV_SIGNED_EN is defined.
module tb_restoring_divider32;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIV_SIGNED_EN
    logic        signed_op;
`endif
    bit          sel_b;

    int n_checks;
    int n_errors;

    restoring_divider32_if bus_a ();
    restoring_divider32_if bus_b ();

    assign bus_a.start    = start;
    assign bus_a.dividend = dividend;
    assign bus_a.divisor  = divisor;
    assign bus_b.start    = start;
    assign bus_b.dividend = dividend;
    assign bus_b.divisor  = divisor;
`ifdef DIV_SIGNED_EN
    assign bus_a.signed_op = signed_op;
    assign bus_b.signed_op = signed_op;
`endif

    restoring_divider32 #(.EARLY_ZERO(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    restoring_divider32 #(.EARLY_ZERO(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic        o_busy;
    logic        o_done;
    logic [31:0] o_quot;
    logic [31:0] o_rem;
    logic        o_dbz;

    assign o_busy = sel_b ? bus_b.busy        : bus_a.busy;
    assign o_done = sel_b ? bus_b.done        : bus_a.done;
    assign o_quot = sel_b ? bus_b.quotient    : bus_a.quotient;
    assign o_rem  = sel_b ? bus_b.remainder   : bus_a.remainder;
    assign o_dbz  = sel_b ? bus_b.div_by_zero : bus_a.div_by_zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for done, then check latency and results.
    // inject_at >= 0 pulses a 9/3 start at that cycle while busy; chain skips the hold check
    // so the caller can start again in the done cycle.
    task automatic run_op(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input int lat, input int inject_at, input bit chain);
        int n;
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0005;
        if (lat > 0) check({tag, " busy"}, {31'd0, o_busy}, 32'd1);
        n = 0;
        while (!o_done && n < lat + 8) begin
            if (n == inject_at) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " quotient"}, o_quot, eq);
        check({tag, " remainder"}, o_rem, er);
        check({tag, " div_by_zero"}, {31'd0, o_dbz}, {31'd0, edbz});
        check({tag, " busy_at_done"}, {31'd0, o_busy}, 32'd0);
        if (!chain) begin
            tick();
            check({tag, " done_cleared"}, {31'd0, o_done}, 32'd0);
            check({tag, " quotient_held"}, o_quot, eq);
            check({tag, " remainder_held"}, o_rem, er);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        sel_b     = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        tick();
        tick();
        check("reset busy", {31'd0, o_busy}, 32'd0);
        check("reset done", {31'd0, o_done}, 32'd0);
        check("reset quotient", o_quot, 32'd0);
        check("reset remainder", o_rem, 32'd0);
        check("reset div_by_zero", {31'd0, o_dbz}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, -1, 1'b0);
        run_op("max/msb", 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, LAT, -1, 1'b0);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, -1, 1'b0);

        // Full-length zero divide on the EARLY_ZERO=0 instance, then the early path.
        sel_b = 1'b1;
        run_op("1234/0 full", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, LAT, -1, 1'b0);
        sel_b = 1'b0;
        run_op("1234/0 early", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0, -1, 1'b0);

        run_op("50/5 ignore", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, LAT, 10, 1'b1);
        run_op("81/9 chained", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, LAT, -1, 1'b0);

        // Abort mid-operation with an asynchronous reset.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, o_busy}, 32'd0);
        check("abort done", {31'd0, o_done}, 32'd0);
        check("abort quotient", o_quot, 32'd0);
        check("abort remainder", o_rem, 32'd0);
        check("abort div_by_zero", {31'd0, o_dbz}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < LAT + 4; i++) begin
                tick();
                if (o_done) seen++;
            end
            check("abort no done", 32'(seen), 32'd0);
        end
        run_op("9/4 after reset", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, LAT, -1, 1'b0);

`ifdef DIV_SIGNED_EN
        signed_op = 1'b1;
        run_op("-100/7 signed", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT, -1, 1'b0);
        run_op("min/-1 signed", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT, -1, 1'b0);
        signed_op = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
